// File: rtl/fifo_frame_writer.sv
// rtl/fifo_frame_writer.sv - framed word stream to async FIFO write port with length/checksum trailer
//
// Purpose:
//   Write-domain producer for the asynchronous FIFO. Payload words of each
//   frame pass straight through to the FIFO (tag 0). After the last word
//   two trailer words are appended (tag 1): payload length, then the XOR
//   checksum of the payload. Frames longer than MAX_LEN are truncated; the
//   excess words are consumed and discarded.
//
// Ports:
//   wclk, wrst_n  write clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   upstream word stream with frame end marker
//   fifo_wr_en/fifo_wdata/fifo_wfull FIFO write port, fifo_wdata = {tag, word}
//   frame_cnt     number of trailers completed (wraps)
//   err_long      one-cycle pulse the cycle after a truncating accept
//   busy          a frame is in progress or trailer/drop pending
module fifo_frame_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH:0]   fifo_wdata,
  input  logic                  fifo_wfull,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  err_long,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_TLEN = 2'd1,
    ST_TSUM = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  err_long_q, err_long_d;

  logic [DATA_WIDTH-1:0] len_inc;

  assign len_inc = len_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    trunc_d     = trunc_q;
    frame_cnt_d = frame_cnt_q;
    err_long_d  = 1'b0;
    s_ready     = 1'b0;
    fifo_wr_en  = 1'b0;
    fifo_wdata  = {1'b0, s_data};

    case (state_q)
      ST_DATA: begin
        s_ready = !fifo_wfull;
        if (s_valid && !fifo_wfull) begin
          // Payload goes to the FIFO in the same cycle it is accepted.
          fifo_wr_en = 1'b1;
          len_d      = len_inc;
          sum_d      = sum_q ^ s_data;
          if (s_last) begin
            state_d = ST_TLEN;
          end else if (len_inc == MAX_LEN_W) begin
            // Frame still open at the length limit: close it here and
            // swallow the rest of it in DROP after the trailer.
            state_d    = ST_TLEN;
            trunc_d    = 1'b1;
            err_long_d = 1'b1;
          end
        end
      end

      ST_TLEN: begin
        fifo_wr_en = !fifo_wfull;
        fifo_wdata = {1'b1, len_q};
        if (!fifo_wfull) begin
          state_d = ST_TSUM;
        end
      end

      ST_TSUM: begin
        fifo_wr_en = !fifo_wfull;
        fifo_wdata = {1'b1, sum_q};
        if (!fifo_wfull) begin
          len_d       = '0;
          sum_d       = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = trunc_q ? ST_DROP : ST_DATA;
        end
      end

      ST_DROP: begin
        // Nothing is written here, so FIFO fullness does not matter.
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_d = ST_DATA;
          trunc_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_DATA;
      len_q       <= '0;
      sum_q       <= '0;
      trunc_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      trunc_q     <= trunc_d;
      frame_cnt_q <= frame_cnt_d;
      err_long_q  <= err_long_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_long  = err_long_q;
  assign busy      = (len_q != '0) || (state_q != ST_DATA);

endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb/tb_fifo_frame_writer.sv - self-checking bench for fifo_frame_writer
module tb_fifo_frame_writer;

  localparam int DW      = 8;
  localparam int MAX_LEN = 16;
  localparam int CW      = 16;

  logic          wclk;
  logic          wrst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          fifo_wr_en;
  logic [DW:0]   fifo_wdata;
  logic          fifo_wfull;
  logic [CW-1:0] frame_cnt;
  logic          err_long;
  logic          busy;

  fifo_frame_writer #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN), .CNT_WIDTH(CW)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .frame_cnt  (frame_cnt),
    .err_long   (err_long),
    .busy       (busy)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  typedef struct {
    logic [DW:0] w;
    bit          trunc;
    bit          chk;
  } exp_t;

  exp_t        exp_q[$];
  logic [DW:0] wr_log[$];
  logic [DW:0] lit[$];
  logic [DW-1:0] frm[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  frames_done = 0;
  bit  err_exp = 0;
  int  err_pulses = 0;
  int  srdy_low = 0;
  bit  cnt_en = 0;
  int  full_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Reference: a frame of n words yields its first min(n,MAX_LEN) words,
  // then {1,len} and {1,xor of those words}.
  function automatic void push_model();
    int n = frm.size();
    int k = (n > MAX_LEN) ? MAX_LEN : n;
    logic [DW-1:0] x = '0;
    exp_t e;
    for (int i = 0; i < k; i++) begin
      e.w = {1'b0, frm[i]};
      e.trunc = (n > MAX_LEN) && (i == k - 1);
      e.chk = 0;
      exp_q.push_back(e);
      x = x ^ frm[i];
    end
    e.w = {1'b1, 8'(k)};
    e.trunc = 0;
    e.chk = 0;
    exp_q.push_back(e);
    e.w = {1'b1, x};
    e.chk = 1;
    exp_q.push_back(e);
  endfunction

  // Compare process: every cycle outside reset.
  always @(negedge wclk) begin
    exp_t e;
    if (!wrst_n) begin
      err_exp = 0;
    end else begin
      chk("err_long", {31'd0, err_long}, {31'd0, err_exp});
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, frames_done[15:0]});
      err_exp = 0;
      if (fifo_wr_en) begin
        chk("wr_while_full", {31'd0, fifo_wfull}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, fifo_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_wdata", {23'd0, fifo_wdata}, {23'd0, e.w});
          if (e.trunc) err_exp = 1;
          if (e.chk) frames_done++;
        end
        wr_log.push_back(fifo_wdata);
      end
      if (err_long) err_pulses++;
      if (cnt_en && !s_ready) srdy_low++;
    end
  end

  always @(posedge wclk) begin
    #1;
    if (full_mode == 1) fifo_wfull = ($urandom_range(0, 3) == 0);
    else if (full_mode == 0) fifo_wfull = 1'b0;
  end

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int t = 0;
    logic acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge wclk);
      acc = s_ready;
      step();
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    s_last  = 1'($urandom);
  endtask

  task automatic send_frm(input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      send_word(frm[i], i == frm.size() - 1);
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      step();
      t++;
    end
    chk("drain", exp_q.size(), 32'd0);
    step();
    step();
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, wr_log.size(), lit.size());
    for (int i = 0; i < lit.size() && i < wr_log.size(); i++)
      chk(nm, {23'd0, wr_log[i]}, {23'd0, lit[i]});
  endtask

  task automatic do_reset();
    wrst_n  = 1'b0;
    s_valid = 1'b0;
    step();
    step();
    exp_q.delete();
    frames_done = 0;
    wrst_n = 1'b1;
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_wfull = 1'b0;
    full_mode = 2;

    // Reset state and combinational ready/write gating.
    step();
    s_valid = 1'b1;
    fifo_wfull = 1'b1;
    @(negedge wclk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_err_long", {31'd0, err_long}, 32'd0);
    chk("rst_ready_full", {31'd0, s_ready}, 32'd0);
    chk("rst_wr_full", {31'd0, fifo_wr_en}, 32'd0);
    fifo_wfull = 1'b0;
    #1;
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_wr", {31'd0, fifo_wr_en}, 32'd1);
    s_valid = 1'b0;
    full_mode = 0;
    do_reset();

    // 3-word frame.
    wr_log.delete();
    frm = '{8'h11, 8'h22, 8'h33};
    push_model();
    srdy_low = 0;
    cnt_en = 1;
    send_frm(0);
    repeat (4) step();
    cnt_en = 0;
    lit = '{9'h011, 9'h022, 9'h033, 9'h103, 9'h100};
    check_log("three_word");
    chk("three_word_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("three_word_stall", srdy_low, 32'd2);

    // Single-word frame.
    wr_log.delete();
    frm = '{8'hA5};
    push_model();
    send_frm(0);
    wait_idle();
    lit = '{9'h0A5, 9'h101, 9'h1A5};
    check_log("single_word");

    // Backpressure on word 3 and for 3 cycles of TSUM.
    wr_log.delete();
    frm = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_model();
    full_mode = 2;
    fifo_wfull = 1'b0;
    s_valid = 1'b1; s_last = 1'b0; s_data = 8'h01;
    step();
    s_data = 8'h02;
    step();
    s_data = 8'h03;
    fifo_wfull = 1'b1;
    @(negedge wclk);
    chk("bp_w3_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_w3_wr", {31'd0, fifo_wr_en}, 32'd0);
    step();
    fifo_wfull = 1'b0;
    step();
    s_data = 8'h04; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    fifo_wfull = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      chk("bp_tsum_hold", {31'd0, fifo_wr_en}, 32'd0);
      step();
    end
    fifo_wfull = 1'b0;
    @(negedge wclk);
    chk("bp_tsum_wr", {31'd0, fifo_wr_en}, 32'd1);
    chk("bp_tsum_data", {23'd0, fifo_wdata}, 32'h104);
    step();
    full_mode = 0;
    wait_idle();
    lit = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h104, 9'h104};
    check_log("backpressure");

    // Over-length frame, then a normal one.
    wr_log.delete();
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(8'(i));
    push_model();
    p0 = err_pulses;
    send_frm(0);
    wait_idle();
    chk("long_count", wr_log.size(), 32'd18);
    if (wr_log.size() == 18) begin
      chk("long_tlen", {23'd0, wr_log[16]}, 32'h110);
      chk("long_tsum", {23'd0, wr_log[17]}, 32'h100);
    end
    chk("long_err_pulses", err_pulses - p0, 32'd1);
    wr_log.delete();
    frm = '{8'h5A, 8'hC3};
    push_model();
    send_frm(0);
    wait_idle();
    lit = '{9'h05A, 9'h0C3, 9'h102, 9'h199};
    check_log("after_long");

    // Reset mid-frame.
    frm = '{8'h40, 8'h41};
    begin
      exp_t e;
      e.trunc = 0; e.chk = 0;
      e.w = 9'h040; exp_q.push_back(e);
      e.w = 9'h041; exp_q.push_back(e);
    end
    send_word(8'h40, 1'b0);
    send_word(8'h41, 1'b0);
    @(negedge wclk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("mid_rst_err", {31'd0, err_long}, 32'd0);
    chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("mid_rst_wr", {31'd0, fifo_wr_en}, 32'd0);
    exp_q.delete();
    frames_done = 0;
    step();
    wrst_n = 1'b1;
    step();
    wr_log.delete();
    frm = '{8'h7E};
    push_model();
    send_frm(0);
    wait_idle();
    lit = '{9'h07E, 9'h101, 9'h17E};
    check_log("post_reset");

    // Random back-to-back frames with random backpressure.
    do_reset();
    full_mode = 1;
    for (int f = 0; f < 256; f++) begin
      n = $urandom_range(1, 16);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      push_model();
      send_frm(1);
    end
    full_mode = 0;
    wait_idle();
    chk("random_frame_cnt", {16'd0, frame_cnt}, 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_frame_writer.md
# fifo_frame_writer

Write-clock-domain producer that drives the write port of the team's asynchronous FIFO. It accepts a valid/ready word stream with frame delimiters and writes each frame's payload into the FIFO. After each frame it appends two trailer words: payload length and XOR checksum. Each written word carries a tag bit so the read-side consumer can find frame boundaries. It truncates over-length frames and honours FIFO backpressure via `fifo_wfull`.

## Interface
- `DATA_WIDTH`, 8, payload word width; FIFO is instantiated with width DATA_WIDTH+1.
- `MAX_LEN`, 16, maximum payload words per frame; legal range 2 .. 2^DATA_WIDTH-1.
- `CNT_WIDTH`, 16, width of `frame_cnt`.
- `wclk`  in  1  write-domain clock; all state on rising edge.
- `wrst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  upstream ready (combinational).
- `s_data`  in  DATA_WIDTH  upstream payload word.
- `s_last`  in  1  marks final word of frame.
- `fifo_wr_en`  out  1  FIFO write strobe (combinational).
- `fifo_wdata`  out  DATA_WIDTH+1  {tag, word}; tag 0 = payload, 1 = trailer.
- `fifo_wfull`  in  1  FIFO full flag, write domain.
- `frame_cnt`  out  CNT_WIDTH  trailers completed, wraps modulo 2^CNT_WIDTH.
- `err_long`  out  1  one-cycle pulse on truncation.
- `busy`  out  1  high when `len` ≠ 0 or state ≠ DATA.

## Operation
- Registers:
  - state ∈ {DATA, TLEN, TSUM, DROP}.
  - `len` (DATA_WIDTH bits): payload words so far.
  - `sum` (DATA_WIDTH bits): XOR of payload words so far.
  - `trunc` (1 bit): truncation pending.
  - `frame_cnt`, `err_long`.
- Reset values: state DATA, `len`=0, `sum`=0, `trunc`=0, `frame_cnt`=0, `err_long`=0, `busy`=0.
- After reset, `s_ready`=!fifo_wfull and `fifo_wr_en` = s_valid & !fifo_wfull.

**DATA state**
- `s_ready` = !fifo_wfull.
- Accept = s_valid & s_ready; on accept:
  - `fifo_wr_en`=1 and `fifo_wdata`={0, s_data}, same cycle.
  - `len`<=len+1, `sum`<=sum^s_data.
- Transitions on accept:
  - s_last=1 → TLEN.
  - Else if len+1 == MAX_LEN → TLEN with `trunc`<=1 and `err_long`<=1 for one cycle.
  - Else stay in DATA.

**TLEN state**
- `s_ready`=0, `fifo_wr_en` = !fifo_wfull, `fifo_wdata`={1, len}.
- On write → TSUM.

**TSUM state**
- `s_ready`=0, `fifo_wr_en` = !fifo_wfull, `fifo_wdata`={1, sum}.
- On write:
  - `len`<=0, `sum`<=0, `frame_cnt`<=frame_cnt+1.
  - Next state is DROP if `trunc`, else DATA.

**DROP state**
- `s_ready`=1 regardless of `fifo_wfull`; `fifo_wr_en`=0; accepted words are discarded.
- Accepted word with s_last=1 → DATA, `trunc`<=0.

**General rules**
- `fifo_wr_en` is never asserted while `fifo_wfull`=1; no word is lost or duplicated under backpressure.
- `s_data`/`s_last` are sampled only on accept. `s_valid` may drop without acceptance, with no effect.
- Length and checksum are DATA_WIDTH wide. Length never wraps because MAX_LEN < 2^DATA_WIDTH.
- A single-word frame (s_last on the first word) gives len=1 and sum=that word.
- Reset mid-frame: all registers return to reset values immediately and no trailer is written. The system resets the FIFO write side from the same `wrst_n`, so no partial frame survives.

## Timing
- Zero-cycle latency from accepted payload word to FIFO write.
- The trailer takes 2 cycles minimum after the last payload word, plus one cycle per cycle of `fifo_wfull`.
- Upstream throughput is 1 word/cycle within a frame. Per-frame overhead is 2 stall cycles.
- `err_long` is registered and high for the cycle after the truncating accept.
- `frame_cnt` updates the cycle after the TSUM write.
- `fifo_wfull` is sampled combinationally in the same cycle it gates writes.

## Test plan
- Reset then 3-word frame 0x11, 0x22, 0x33 (last on 0x33), fifo_wfull=0:
  - FIFO receives 0x011, 0x022, 0x033, 0x103, 0x100 (0x11^0x22^0x33=0x00).
  - frame_cnt=1; s_ready low exactly 2 cycles.
- Single-word frame 0xA5 → FIFO gets 0x0A5, 0x101, 0x1A5.
- Backpressure: 4-word frame 0x01..0x04, fifo_wfull forced high during word 3 and during TSUM for 3 cycles:
  - No write while full; FIFO sequence 0x001..0x004, 0x104, 0x104 (sum 0x04) is exact.
  - Trailer completes 3 cycles late.
- Over-length with MAX_LEN=16: 20-word frame 0x00..0x13, last on 0x13:
  - 16 payload words written, then 0x110 and 0x100 (XOR of 0..15).
  - err_long pulses once; words 0x10..0x13 are consumed with s_ready=1 and not written.
  - The next frame is written normally.
- Reset mid-frame: wrst_n low after 2 words of a frame:
  - All outputs return to reset values, busy=0, frame_cnt=0.
  - The next 1-word frame 0x7E gives len 1 and sum 0x7E.
- Back-to-back 256 frames with random length 1..16, random data, random fifo_wfull:
  - Scoreboard matches every payload/trailer word.
  - frame_cnt=256.
